// File: rtl/aes128_decrypt_core.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys are
// supplied externally from rk10 down to rk0, one per ready_dec edge.
`timescale 1ns/1ps

module aes128_decrypt_core #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] cipher_text,
    input  logic [127:0] key_in,
    output logic         ready_dec,
    output logic [127:0] plain_text,
    output logic         done_dec
);

    typedef enum logic {
        IDLE  = 1'b0,
        ROUND = 1'b1
    } state_t;

    localparam logic [3:0] FIRST_ROUND = 4'(NR - 1);

    // Inverse S-box, byte 0x00 in the most significant byte position.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    state_t       state;
    state_t       state_next;
    logic [3:0]   round_cnt;
    logic [127:0] st;
    logic [127:0] sub_shift;
    logic [127:0] ark;
    logic [127:0] mixed;
    logic         load_init;
    logic         load_round;
    logic         finish;

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [10:0] top;
        top = 11'd2047 - {b, 3'b000};
        return INV_SBOX[top -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiplies one state column by the {0e,0b,0d,09} circulant matrix.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        a[0] = col[31:24];
        a[1] = col[23:16];
        a[2] = col[15:8];
        a[3] = col[7:0];
        for (int k = 0; k < 4; k++) begin
            x2    = xtime(a[k]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[k] = x8 ^ a[k];
            mb[k] = x8 ^ x2 ^ a[k];
            md[k] = x8 ^ x4 ^ a[k];
            me[k] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // InvShiftRows folded into InvSubBytes: row k of column c comes from column c-k.
    for (genvar c = 0; c < 4; c++) begin : gen_col
        for (genvar k = 0; k < 4; k++) begin : gen_row
            assign sub_shift[127 - 8*(4*c + k) -: 8] =
                inv_sbox(st[127 - 8*(4*((c - k + 4) % 4) + k) -: 8]);
        end
        assign mixed[127 - 32*c -: 32] = inv_mix_col(ark[127 - 32*c -: 32]);
    end

    assign ark = sub_shift ^ key_in;

    // State register for the round sequencer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the key-consumption strobe; start is ignored once rounds run.
    always_comb begin
        state_next = state;
        ready_dec  = 1'b0;
        load_init  = 1'b0;
        load_round = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    ready_dec  = 1'b1;
                    load_init  = 1'b1;
                    state_next = ROUND;
                end
            end
            ROUND: begin
                ready_dec = 1'b1;
                if (round_cnt == 4'd0) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else begin
                    load_round = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Round datapath: initial key whitening, full rounds, then the final round into plain_text.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= '0;
            round_cnt  <= 4'd0;
            plain_text <= '0;
            done_dec   <= 1'b0;
        end else begin
            done_dec <= finish;
            if (load_init) begin
                st        <= cipher_text ^ key_in;
                round_cnt <= FIRST_ROUND;
            end else if (load_round) begin
                st        <= mixed;
                round_cnt <= round_cnt - 4'd1;
            end
            if (finish) begin
                plain_text <= ark;
            end
        end
    end

endmodule

// File: tb/tb_aes128_decrypt_core.sv
// Directed testbench for aes128_decrypt_core; models the key schedule as a
// table of FIPS-197 round keys stepped down by ready_dec.
`timescale 1ns/1ps

module tb_aes128_decrypt_core;

    localparam logic [127:0] RK_A [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    localparam logic [127:0] RK_B [0:10] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    // Ciphertexts are the encryption results of the plaintexts under the matching key.
    localparam logic [127:0] CT_A = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_A = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_B = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] cipher_text;
    logic [127:0] key_in;
    logic         ready_dec;
    logic [127:0] plain_text;
    logic         done_dec;

    logic         key_sel;
    logic [3:0]   kidx;
    int           rd_edges = 0;
    int           checks;
    int           errors;

    aes128_decrypt_core #(.NR(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cipher_text (cipher_text),
        .key_in      (key_in),
        .ready_dec   (ready_dec),
        .plain_text  (plain_text),
        .done_dec    (done_dec)
    );

    always #5 clk = ~clk;

    // Key schedule model: rk10 while idle, one step down per consuming edge.
    always_comb key_in = key_sel ? RK_B[kidx] : RK_A[kidx];

    // Step the key index on every edge that consumes a round key.
    always @(posedge clk or posedge reset) begin
        if (reset) kidx <= 4'd10;
        else if (ready_dec) kidx <= (kidx == 4'd0) ? 4'd10 : kidx - 4'd1;
    end

    // Running count of consuming edges.
    always @(posedge clk) begin
        if (ready_dec) rd_edges <= rd_edges + 1;
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (plain_text !== 128'h0) begin
            errors++;
            $display("[TB] FAIL reset_pt: got %h expected %h", plain_text, 128'h0);
        end
        checks++;
        if (done_dec !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_done: got %b expected 0", done_dec);
        end
        checks++;
        if (ready_dec !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 0", ready_dec);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_dec !== 1'b0 || done_dec !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got ready=%b done=%b expected 0 0", ready_dec, done_dec);
        end
    endtask

    task automatic test_fips_a();
        int   base;
        logic exp_done;
        key_sel     = 1'b0;
        cipher_text = CT_A;
        start       = 1'b1;
        base        = rd_edges;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            start       = 1'b0;
            cipher_text = '0;
            exp_done    = (i == 11);
            checks++;
            if (done_dec !== exp_done) begin
                errors++;
                $display("[TB] FAIL fips_a_done_cycle%0d: got %b expected %b", i, done_dec, exp_done);
            end
        end
        checks++;
        if (plain_text !== PT_A) begin
            errors++;
            $display("[TB] FAIL fips_a_pt: got %h expected %h", plain_text, PT_A);
        end
        checks++;
        if (rd_edges - base != 11) begin
            errors++;
            $display("[TB] FAIL fips_a_ready_count: got %0d expected 11", rd_edges - base);
        end
        @(negedge clk);
        checks++;
        if (done_dec !== 1'b0 || plain_text !== PT_A) begin
            errors++;
            $display("[TB] FAIL fips_a_hold: got done=%b pt=%h expected 0 %h", done_dec, plain_text, PT_A);
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] cts [2];
        logic [127:0] pts [2];
        logic         sels [2];
        cts  = '{CT_B, CT_A};
        pts  = '{PT_B, PT_A};
        sels = '{1'b1, 1'b0};
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            key_sel     = sels[v];
            cipher_text = cts[v];
            start       = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (9) @(negedge clk);
            checks++;
            if (done_dec !== 1'b0) begin
                errors++;
                $display("[TB] FAIL round_trip%0d_early_done: got %b expected 0", v, done_dec);
            end
            @(negedge clk);
            checks++;
            if (done_dec !== 1'b1) begin
                errors++;
                $display("[TB] FAIL round_trip%0d_done: got %b expected 1", v, done_dec);
            end
            checks++;
            if (plain_text !== pts[v]) begin
                errors++;
                $display("[TB] FAIL round_trip%0d_pt: got %h expected %h", v, plain_text, pts[v]);
            end
        end
    endtask

    task automatic test_restart_ignored();
        int   base;
        logic exp_done;
        @(negedge clk);
        key_sel     = 1'b0;
        cipher_text = CT_A;
        start       = 1'b1;
        base        = rd_edges;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            start       = (i >= 5 && i <= 7);
            cipher_text = start ? CT_B : CT_A;
            exp_done    = (i == 11);
            checks++;
            if (done_dec !== exp_done) begin
                errors++;
                $display("[TB] FAIL restart_done_cycle%0d: got %b expected %b", i, done_dec, exp_done);
            end
        end
        checks++;
        if (plain_text !== PT_A) begin
            errors++;
            $display("[TB] FAIL restart_pt: got %h expected %h", plain_text, PT_A);
        end
        checks++;
        if (rd_edges - base != 11) begin
            errors++;
            $display("[TB] FAIL restart_ready_count: got %0d expected 11", rd_edges - base);
        end
        @(negedge clk);
        checks++;
        if (ready_dec !== 1'b0 || done_dec !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_idle: got ready=%b done=%b expected 0 0", ready_dec, done_dec);
        end
    endtask

    task automatic test_mid_reset();
        int base;
        int seen;
        @(negedge clk);
        key_sel     = 1'b1;
        cipher_text = CT_B;
        start       = 1'b1;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        #1;
        checks++;
        if (plain_text !== 128'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset_pt: got %h expected %h", plain_text, 128'h0);
        end
        checks++;
        if (ready_dec !== 1'b0 || done_dec !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got ready=%b done=%b expected 0 0", ready_dec, done_dec);
        end
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        repeat (15) begin
            @(negedge clk);
            if (done_dec !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL mid_reset_no_done: got %0d pulses expected 0", seen);
        end
        cipher_text = CT_B;
        start       = 1'b1;
        base        = rd_edges;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (done_dec !== 1'b1 || plain_text !== PT_B) begin
            errors++;
            $display("[TB] FAIL mid_reset_fresh: got done=%b pt=%h expected 1 %h", done_dec, plain_text, PT_B);
        end
        checks++;
        if (rd_edges - base != 11) begin
            errors++;
            $display("[TB] FAIL mid_reset_ready_count: got %0d expected 11", rd_edges - base);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        @(negedge clk);
        key_sel     = 1'b0;
        cipher_text = CT_A;
        start       = 1'b1;
        base        = rd_edges;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 11) begin
                checks++;
                if (done_dec !== 1'b1 || plain_text !== PT_A) begin
                    errors++;
                    $display("[TB] FAIL b2b_first: got done=%b pt=%h expected 1 %h", done_dec, plain_text, PT_A);
                end
                key_sel     = 1'b1;
                cipher_text = CT_B;
                start       = 1'b1;
            end else if (i >= 12 && i <= 21) begin
                checks++;
                if (done_dec !== 1'b0 || plain_text !== PT_A) begin
                    errors++;
                    $display("[TB] FAIL b2b_hold_cycle%0d: got done=%b pt=%h expected 0 %h", i, done_dec, plain_text, PT_A);
                end
            end else if (i == 22) begin
                checks++;
                if (done_dec !== 1'b1 || plain_text !== PT_B) begin
                    errors++;
                    $display("[TB] FAIL b2b_second: got done=%b pt=%h expected 1 %h", done_dec, plain_text, PT_B);
                end
            end
        end
        checks++;
        if (rd_edges - base != 22) begin
            errors++;
            $display("[TB] FAIL b2b_ready_count: got %0d expected 22", rd_edges - base);
        end
        @(negedge clk);
        checks++;
        if (done_dec !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_done_clear: got %b expected 0", done_dec);
        end
    endtask

    // Guard against a stuck simulation.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        start       = 1'b0;
        cipher_text = '0;
        key_sel     = 1'b0;
        test_reset();
        test_fips_a();
        test_round_trip();
        test_restart_ignored();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
